// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and helpers for the memory arbiter.
//   MAX_MASTERS     : upper bound on the number of requesting masters
//   midx_t          : master index wide enough for MAX_MASTERS
//   mem_req_t       : request payload sized for the widest supported build
//   rr_dist()       : round-robin distance of master k from the priority pointer
package mem_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_ADDR_W  = 64;
  localparam int MAX_DATA_W  = 128;
  localparam int MAX_BE_W    = MAX_DATA_W / 8;

  typedef logic [$clog2(MAX_MASTERS)-1:0] midx_t;

  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [MAX_BE_W-1:0]   be;
    logic                  we;
  } mem_req_t;

  // Number of positions master k sits after ptr in the circular search order.
  function automatic int rr_dist(input int k, input int ptr, input int n);
    int d;
    d = k - ptr;
    if (d < 0) d += n;
    return d;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick -- combinational round-robin picker.
//   req   : request vector
//   ptr   : priority pointer, the first index searched
//   gnt   : one-hot pick (zero when nothing requests)
//   valid : a pick was made
module mem_arb_rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  midx_t        ptr,
  output logic [N-1:0] gnt,
  output logic         valid
);

  // Pick the requester closest to ptr going upward with wrap.
  always_comb begin
    int best;
    best = N;
    gnt  = '0;
    for (int k = 0; k < N; k++)
      if (req[k] && rr_dist(k, int'(ptr), N) < best) best = rr_dist(k, int'(ptr), N);
    for (int k = 0; k < N; k++)
      gnt[k] = req[k] && (rr_dist(k, int'(ptr), N) == best);
    valid = |req;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin arbiter of NUM_MASTERS masters onto one memory port.
//   m_req/m_addr/m_wdata/m_be/m_we : per-master request and payload
//   m_gnt    : one-hot accept strobe (selected master, s_hit=1)
//   m_rvalid : per-master read-data valid, one cycle after a read accept
//   m_rdata  : shared read data, zero when no m_rvalid is set
//   s_*      : memory-side request; s_hit accepts it, s_data_o returns read data
// Optional build macro MEM_ARB_LOCK_EN adds m_lock: a master that is accepted
// with its lock bit set keeps the selection and the pointer stays put.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_MASTERS-1:0]              m_req,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata,
  input  logic [NUM_MASTERS-1:0][BE_W-1:0]    m_be,
  input  logic [NUM_MASTERS-1:0]              m_we,
`ifdef MEM_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]              m_lock,
`endif
  output logic [NUM_MASTERS-1:0]              m_gnt,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic [ADDR_W-1:0]                   s_addr,
  output logic [DATA_W-1:0]                   s_data_i,
  output logic [BE_W-1:0]                     s_data_en,
  output logic                                s_write_en,
  input  logic [DATA_W-1:0]                   s_data_o,
  input  logic                                s_hit
);

  midx_t                  ptr, hold_idx, rsp_idx, sel_idx;
  logic                   hold_vld, rsp_vld;
  logic [NUM_MASTERS-1:0] pick_oh, hold_oh, sel_oh;
  logic                   pick_vld, sel_vld, accept, sel_lock;
  mem_req_t               sel_req;

  mem_arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (m_req),
    .ptr   (ptr),
    .gnt   (pick_oh),
    .valid (pick_vld)
  );

`ifdef MEM_ARB_LOCK_EN
  midx_t                  lock_idx;
  logic                   lock_vld;
  logic [NUM_MASTERS-1:0] lock_oh;
`endif

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      hold_oh[i] = (hold_idx == midx_t'(i));
`ifdef MEM_ARB_LOCK_EN
      lock_oh[i] = (lock_idx == midx_t'(i));
`endif
    end
  end

  // A stalled selection sticks while its master keeps requesting; once it
  // drops, the picker restarts from the unchanged pointer in the same cycle.
  always_comb begin
    sel_oh = pick_oh;
    if (hold_vld && |(m_req & hold_oh)) sel_oh = hold_oh;
`ifdef MEM_ARB_LOCK_EN
    else if (lock_vld && |(m_req & lock_oh)) sel_oh = lock_oh;
`endif
    sel_vld = pick_vld;
    sel_idx = '0;
    sel_req = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (sel_oh[i]) begin
        sel_idx       = midx_t'(i);
        sel_req.addr  = MAX_ADDR_W'(m_addr[i]);
        sel_req.wdata = MAX_DATA_W'(m_wdata[i]);
        sel_req.be    = MAX_BE_W'(m_be[i]);
        sel_req.we    = m_we[i];
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  assign sel_lock = |(m_lock & sel_oh);
`else
  assign sel_lock = 1'b0;
`endif

  assign accept     = sel_vld & s_hit;
  assign m_gnt      = {NUM_MASTERS{accept}} & sel_oh;
  // Idle presents all-zero request fields because sel_req defaults to zero.
  assign s_addr     = ADDR_W'(sel_req.addr);
  assign s_data_i   = DATA_W'(sel_req.wdata);
  assign s_data_en  = BE_W'(sel_req.be);
  assign s_write_en = sel_req.we;

  assign m_rdata = rsp_vld ? s_data_o : '0;
  always_comb
    for (int i = 0; i < NUM_MASTERS; i++)
      m_rvalid[i] = rsp_vld && (rsp_idx == midx_t'(i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      hold_vld <= 1'b0;
      hold_idx <= '0;
      rsp_vld  <= 1'b0;
      rsp_idx  <= '0;
    end else begin
      hold_vld <= sel_vld && !s_hit;
      hold_idx <= sel_idx;
      rsp_vld  <= accept && !sel_req.we;
      rsp_idx  <= sel_idx;
      if (accept && !sel_lock)
        ptr <= (sel_idx == midx_t'(NUM_MASTERS - 1)) ? '0 : sel_idx + midx_t'(1);
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
    end else if (accept) begin
      lock_vld <= sel_lock;
      lock_idx <= sel_idx;
    end else if (lock_vld && !(|(m_req & lock_oh))) begin
      lock_vld <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2: number of requesting masters, range 2..8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width, multiple of 8; byte-enable width BE_W = DATA_W/8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 m_req  input  NUM_MASTERS  per-master request valid.
REQ-007 m_addr, m_wdata, m_be, m_we  input  NUM_MASTERS x ADDR_W / DATA_W / BE_W / 1  per-master request payload.
REQ-008 m_gnt  output  NUM_MASTERS  request accepted this cycle, one-hot or zero.
REQ-009 m_rvalid  output  NUM_MASTERS  read data valid for that master this cycle.
REQ-010 m_rdata  output  DATA_W  read data, shared by all masters, qualified by m_rvalid.
REQ-011 s_addr, s_data_i, s_data_en, s_write_en  output  ADDR_W / DATA_W / BE_W / 1  memory-side request.
REQ-012 s_data_o  input  DATA_W  memory read data.
REQ-013 s_hit  input  1  memory accepts the presented address; read data valid next cycle.

Function
REQ-014 Accept: request accepted in a cycle when the arbiter selects a master, that master's m_req=1, and s_hit=1; m_gnt of that master is 1 in the same cycle.
REQ-015 Selection: round-robin; search starts at priority pointer ptr, ptr = (accepted index + 1) mod NUM_MASTERS after every accept.
REQ-016 Hold: once selected and not accepted (s_hit=0), the selection is held until accepted or until that master drops m_req; s_addr/s_data_i/s_data_en/s_write_en stay stable meanwhile.
REQ-017 Dropped request: if the held master drops m_req, arbitration restarts the same cycle from ptr; ptr is unchanged.
REQ-018 Idle: with no m_req asserted, s_write_en=0, s_data_en=0, s_addr=0, s_data_i=0.
REQ-019 Read response: accepted read (m_we=0) registers owner index; next cycle m_rvalid[owner]=1 and m_rdata=s_data_o.
REQ-020 Writes: accepted write produces no m_rvalid.
REQ-021 Pipelining: one accept per cycle sustained; response for cycle t's accept coincides with cycle t+1's accept.
REQ-022 Latency: zero combinational cycles request-to-memory when selected; read data one cycle after accept.
REQ-023 m_rdata SHALL be 0 in cycles where no m_rvalid is asserted.

Reset
REQ-024 On rst_n=0: ptr=0, hold state cleared, pending response cleared, m_rvalid=0, m_rdata=0.
REQ-025 Reset mid-transaction: pending read response is discarded; no m_rvalid in first cycle after release.

Configuration
REQ-026 Macro MEM_ARB_LOCK_EN defined: adds input m_lock (NUM_MASTERS); after an accept from master k with m_lock[k]=1, master k keeps selection and ptr does not advance until an accept from k with m_lock[k]=0 or k drops m_req.
REQ-027 Macro MEM_ARB_LOCK_EN undefined: m_lock port absent; pure round-robin per REQ-015.

Structure
REQ-028 Package mem_arb_pkg holds MAX_MASTERS constant, master-index typedef, and request payload struct typedef.
REQ-029 One sub-module mem_arb_rr_pick: combinational round-robin pick (req vector, ptr -> one-hot grant, valid).

Verification
REQ-030 Masters 0,1 both request reads continuously, s_hit=1 -> grants alternate 0,1,0,1; each m_rvalid one cycle after its grant.
REQ-031 Master 1 write addr 0x40, be 0x3, s_hit=0 for 3 cycles then 1 -> s_addr=0x40 stable 4 cycles, m_gnt[1] only in 4th, no m_rvalid.
REQ-032 Master 0 selected, s_hit=0, drops m_req; master 1 requesting -> master 1 selected same cycle, ptr unchanged.
REQ-033 Read accepted, rst_n asserted next cycle -> m_rvalid stays 0, after release first grant goes to master 0.
REQ-034 MEM_ARB_LOCK_EN: master 0 locked for 3 accepts with master 1 requesting -> 3 consecutive grants to 0, then grant to 1.
REQ-035 NUM_MASTERS=4, DATA_W=64, all requesting -> grant order 0,1,2,3,0 with BE_W=8 byte enables passed unchanged.
